// File: rtl/clock_pkg.sv
// Shared state type and default widths for the CPU run/stop/step clock controller.
package clock_pkg;

    typedef enum logic [1:0] {
        STOP = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        HALT = 2'b11
    } ctrl_state_t;

    localparam int DIV_W_DEFAULT = 24;
    localparam int DEB_W_DEFAULT = 8;

endpackage

// File: rtl/clock_ctrl_btn_debounce.sv
// Front-panel button conditioner: 2-flop synchroniser, saturating up/down counter with
// hysteresis on the debounced level, and a one-cycle pulse on each 0->1 level edge.
module btn_debounce #(
    parameter int DEB_W = 8
) (
    input  logic system_clock,
    input  logic reset_n,
    input  logic btn_i,
    output logic press_o
);

    localparam logic [DEB_W-1:0] CNT_MAX  = {DEB_W{1'b1}};
    localparam logic [DEB_W-1:0] CNT_ZERO = {DEB_W{1'b0}};
    localparam logic [DEB_W-1:0] CNT_ONE  = {{(DEB_W-1){1'b0}}, 1'b1};

    logic             sync1_q;
    logic             sync2_q;
    logic [DEB_W-1:0] cnt_q;
    logic [DEB_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;

    // Saturating integrator: climbs while the synced input is high, drains while low.
    always_comb begin
        cnt_d = cnt_q;
        if (sync2_q) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            if (cnt_q != CNT_ZERO) begin
                cnt_d = cnt_q - CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Level only moves at the counter extremes, so partial bounces leave it unchanged.
    always_comb begin
        level_d = level_q;
        if (cnt_q == CNT_MAX) begin
            level_d = 1'b1;
        end else if (cnt_q == CNT_ZERO) begin
            level_d = 1'b0;
        end else begin
            level_d = level_q;
        end
        press_d = level_d & ~level_q;
    end

    // Synchroniser, counter, level and press registers.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= CNT_ZERO;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/clock_ctrl.sv
// CPU clock controller: produces a registered one-cycle clk_en strobe in the system_clock
// domain from run/stop/step buttons, a programmable run-mode divider and the CPU HLT request.
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int DIV_W        = DIV_W_DEFAULT,
    parameter int DEB_W        = DEB_W_DEFAULT,
    parameter bit RUN_AT_RESET = 1'b0
) (
    input  logic             system_clock,
    input  logic             reset_n,
    input  logic             run_btn,
    input  logic             step_btn,
    input  logic             halt_req,
    input  logic [DIV_W-1:0] div_val,
    output logic             clk_en,
    output logic             cpu_clk,
    output logic             running,
    output logic             halted
);

    localparam ctrl_state_t      RESET_STATE = RUN_AT_RESET ? RUN : STOP;
    localparam logic [DIV_W-1:0] DIV_ZERO    = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE     = {{(DIV_W-1){1'b0}}, 1'b1};

    ctrl_state_t      state_q;
    ctrl_state_t      state_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             clk_en_q;
    logic             clk_en_d;
    logic             cpu_clk_q;
    logic             cpu_clk_d;
    logic             running_q;
    logic             halted_q;
    logic             run_press;
    logic             step_press;

    btn_debounce #(.DEB_W(DEB_W)) u_run_deb (
        .system_clock (system_clock),
        .reset_n      (reset_n),
        .btn_i        (run_btn),
        .press_o      (run_press)
    );

    btn_debounce #(.DEB_W(DEB_W)) u_step_deb (
        .system_clock (system_clock),
        .reset_n      (reset_n),
        .btn_i        (step_btn),
        .press_o      (step_press)
    );

    // Next state, divider and strobe; halt_req overrides any button press in the same cycle.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        clk_en_d = 1'b0;
        case (state_q)
            STOP: begin
                if (halt_req) begin
                    state_d = HALT;
                end else if (run_press) begin
                    state_d = RUN;
                    div_d   = div_val;
                end else if (step_press) begin
                    state_d = STEP;
                end else begin
                    state_d = STOP;
                end
            end
            RUN: begin
                if (div_q == DIV_ZERO) begin
                    clk_en_d = 1'b1;
                    div_d    = div_val;
                end else begin
                    div_d    = div_q - DIV_ONE;
                end
                if (halt_req) begin
                    state_d = HALT;
                end else if (run_press) begin
                    state_d = STOP;
                end else begin
                    state_d = RUN;
                end
            end
            STEP: begin
                clk_en_d = 1'b1;
                if (halt_req) begin
                    state_d = HALT;
                end else begin
                    state_d = STOP;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = STOP;
            end
        endcase
        cpu_clk_d = cpu_clk_q ^ clk_en_d;
    end

    // State, divider and registered outputs.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RESET_STATE;
            div_q     <= DIV_ZERO;
            clk_en_q  <= 1'b0;
            cpu_clk_q <= 1'b0;
            running_q <= RUN_AT_RESET;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            clk_en_q  <= clk_en_d;
            cpu_clk_q <= cpu_clk_d;
            running_q <= (state_d == RUN);
            halted_q  <= (state_d == HALT);
        end
    end

    assign clk_en  = clk_en_q;
    assign cpu_clk = cpu_clk_q;
    assign running = running_q;
    assign halted  = halted_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed-plus-random bench for clock_ctrl against a cycle-level behavioural model.
module tb_clock_ctrl;

    localparam int DEB_W   = 4;
    localparam int DIV_W   = 8;
    localparam int CNT_MAX = (1 << DEB_W) - 1;
    localparam int M_STOP  = 0;
    localparam int M_RUN   = 1;
    localparam int M_STEP  = 2;
    localparam int M_HALT  = 3;

    logic             system_clock = 1'b0;
    logic             reset_n;
    logic             run_btn;
    logic             step_btn;
    logic             halt_req;
    logic [DIV_W-1:0] div_val;
    logic             clk_en;
    logic             cpu_clk;
    logic             running;
    logic             halted;

    int tests   = 0;
    int failed  = 0;
    int strobes = 0;

    // Reference model state: per button [0]=run, [1]=step
    bit m_sy0 [2];
    bit m_sy1 [2];
    int m_cnt [2];
    bit m_lvl [2];
    bit m_press [2];
    int m_state;
    int m_div;
    bit m_en;
    bit m_cpu;

    clock_ctrl #(
        .DIV_W        (DIV_W),
        .DEB_W        (DEB_W),
        .RUN_AT_RESET (1'b0)
    ) dut (
        .system_clock (system_clock),
        .reset_n      (reset_n),
        .run_btn      (run_btn),
        .step_btn     (step_btn),
        .halt_req     (halt_req),
        .div_val      (div_val),
        .clk_en       (clk_en),
        .cpu_clk      (cpu_clk),
        .running      (running),
        .halted       (halted)
    );

    always #5 system_clock = ~system_clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_sy0[b] = 1'b0; m_sy1[b] = 1'b0; m_cnt[b] = 0;
            m_lvl[b] = 1'b0; m_press[b] = 1'b0;
        end
        m_state = M_STOP;
        m_div   = 0;
        m_en    = 1'b0;
        m_cpu   = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit raw [2];
        bit nl;
        int ns;
        bit en;
        if (!reset_n) begin
            model_reset();
            return;
        end
        en = 1'b0;
        ns = m_state;
        case (m_state)
            M_STOP: begin
                if (halt_req) ns = M_HALT;
                else if (m_press[0]) begin ns = M_RUN; m_div = int'(div_val); end
                else if (m_press[1]) ns = M_STEP;
            end
            M_RUN: begin
                if (m_div == 0) begin en = 1'b1; m_div = int'(div_val); end
                else m_div = m_div - 1;
                if (halt_req) ns = M_HALT;
                else if (m_press[0]) ns = M_STOP;
            end
            M_STEP: begin
                en = 1'b1;
                ns = halt_req ? M_HALT : M_STOP;
            end
            default: ns = M_HALT;
        endcase
        if (en) m_cpu = !m_cpu;
        m_en    = en;
        m_state = ns;
        raw[0] = run_btn;
        raw[1] = step_btn;
        for (int b = 0; b < 2; b++) begin
            if (m_cnt[b] == CNT_MAX) nl = 1'b1;
            else if (m_cnt[b] == 0) nl = 1'b0;
            else nl = m_lvl[b];
            m_press[b] = nl && !m_lvl[b];
            m_lvl[b]   = nl;
            if (m_sy1[b]) m_cnt[b] = (m_cnt[b] < CNT_MAX) ? m_cnt[b] + 1 : CNT_MAX;
            else          m_cnt[b] = (m_cnt[b] > 0) ? m_cnt[b] - 1 : 0;
            m_sy1[b] = m_sy0[b];
            m_sy0[b] = raw[b];
        end
    endtask

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            model_edge();
            @(posedge system_clock);
            #1;
            check("clk_en", clk_en, m_en);
            check("cpu_clk", cpu_clk, m_cpu);
            check("running", running, m_state == M_RUN);
            check("halted", halted, m_state == M_HALT);
            if (clk_en) strobes++;
        end
    endtask

    task automatic press(input int which, input int hold);
        if (which == 0) run_btn = 1'b1; else step_btn = 1'b1;
        cycle(hold);
        run_btn  = 1'b0;
        step_btn = 1'b0;
        cycle(25);
    endtask

    task automatic wait_strobe(input string tag);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            cycle(1);
            if (clk_en) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, found, 1'b1);
    endtask

    initial begin
        bit hit;
        reset_n  = 1'b0;
        run_btn  = 1'b0;
        step_btn = 1'b0;
        halt_req = 1'b0;
        div_val  = 8'd3;
        model_reset();
        #3;
        check("rst_clk_en", clk_en, 1'b0);
        check("rst_cpu_clk", cpu_clk, 1'b0);
        check("rst_running", running, 1'b0);
        check("rst_halted", halted, 1'b0);
        cycle(3);
        reset_n = 1'b1;
        strobes = 0;
        cycle(100);
        check_int("idle_strobes", strobes, 0);

        // Enter RUN with period 4
        press(0, 30);
        check("run_entered", running, 1'b1);
        strobes = 0;
        cycle(20);
        check_int("run_period4", strobes, 5);

        // div_val change mid-count waits for the next reload
        wait_strobe("wait_strobe_div");
        div_val = 8'd0;
        cycle(4);
        strobes = 0;
        cycle(10);
        check_int("run_period1", strobes, 10);

        for (int r = 0; r < 5; r++) begin
            div_val = 8'($urandom_range(0, 6));
            cycle(20);
        end
        div_val = 8'd3;

        // Second run press stops
        press(0, 30);
        check("stopped", running, 1'b0);
        strobes = 0;
        cycle(30);
        check_int("stop_strobes", strobes, 0);

        // Single step, held long: one strobe only
        strobes  = 0;
        step_btn = 1'b1;
        cycle(30);
        check_int("step_one", strobes, 1);
        cycle(40);
        check_int("step_hold", strobes, 1);
        step_btn = 1'b0;
        cycle(25);
        check("step_back_stop", running, 1'b0);

        // Bounce and glitch rejection
        strobes = 0;
        for (int k = 0; k < 40; k++) begin
            run_btn = ((k / 3) % 2) == 0;
            cycle(1);
        end
        run_btn = 1'b0;
        cycle(25);
        check("bounce_no_run", running, 1'b0);
        run_btn = 1'b1;
        cycle(10);
        run_btn = 1'b0;
        cycle(25);
        check("glitch_no_run", running, 1'b0);
        for (int g = 0; g < 3; g++) begin
            run_btn = 1'b1;
            cycle(int'($urandom_range(1, CNT_MAX - 3)));
            run_btn = 1'b0;
            cycle(25);
        end
        check_int("glitch_strobes", strobes, 0);

        // Halt together with a run press while running
        press(0, 30);
        check("run_before_halt", running, 1'b1);
        run_btn = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (m_press[0]) begin
                halt_req = 1'b1;
                cycle(1);
                halt_req = 1'b0;
                hit = 1'b1;
                break;
            end
            cycle(1);
        end
        check("halt_press_aligned", hit, 1'b1);
        cycle(5);
        run_btn = 1'b0;
        check("halted_set", halted, 1'b1);
        check("halted_not_running", running, 1'b0);
        strobes = 0;
        cycle(20);
        press(1, 30);
        press(0, 30);
        check_int("halt_strobes", strobes, 0);
        check("halt_sticky", halted, 1'b1);
        reset_n = 1'b0;
        #2;
        model_reset();
        check("halt_rst_halted", halted, 1'b0);
        check("halt_rst_running", running, 1'b0);
        cycle(2);
        reset_n = 1'b1;
        cycle(5);

        // Reset between strobes while running
        div_val = 8'd5;
        press(0, 30);
        wait_strobe("wait_strobe_rst");
        cycle(2);
        reset_n = 1'b0;
        #2;
        model_reset();
        check("mid_rst_clk_en", clk_en, 1'b0);
        check("mid_rst_cpu_clk", cpu_clk, 1'b0);
        check("mid_rst_running", running, 1'b0);
        cycle(3);
        reset_n = 1'b1;
        strobes = 0;
        cycle(30);
        check_int("post_rst_strobes", strobes, 0);
        div_val = 8'd2;
        press(0, 30);
        strobes = 0;
        cycle(30);
        check_int("post_rst_period3", strobes, 10);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
Run/stop/single-step controller for the CPU clock.
- Generates a one-cycle clock-enable strobe (clk_en) from the free-running system_clock; the whole CPU advances on clk_en.
- Driven by two raw front-panel buttons and the CPU's HLT request.
- Replaces gated-clock generation with a synchronous enable, so the CPU stays in the system_clock domain.

Parameters:
DIV_W, 24, width of the run-mode divider reload value
DEB_W, 8, width of each button debounce counter; settle time is 2^DEB_W-1 cycles
RUN_AT_RESET, 0, 1 = enter RUN after reset, 0 = enter STOP

Ports:
system_clock  in  1  sole clock, rising edge
reset_n  in  1  asynchronous, active-low reset
run_btn  in  1  raw run/stop toggle button, active-high, asynchronous
step_btn  in  1  raw single-step button, active-high, asynchronous
halt_req  in  1  CPU HLT request, active-high, synchronous to system_clock
div_val  in  DIV_W  run-mode period minus 1, in system_clock cycles
clk_en  out  1  one-cycle CPU advance strobe
cpu_clk  out  1  display level; toggles on every clk_en
running  out  1  high in RUN state
halted  out  1  high in HALT state

Behaviour:
- One clock domain; all flops use system_clock and asynchronous reset_n.
- Reset values:
  - clk_en=0, cpu_clk=0, halted=0.
  - running=RUN_AT_RESET; state is STOP, or RUN when RUN_AT_RESET=1.
  - Divider count is loaded with 0; debounce counters and debounced levels are 0.
- Button path, per button:
  - 2-flop synchroniser.
  - Saturating DEB_W counter: +1 while the synced input is 1 and the count is below all-ones; -1 while the input is 0 and the count is above 0.
  - Debounced level sets at all-ones, clears at 0, and holds otherwise (hysteresis).
  - A press is a 0->1 edge of the debounced level: a one-cycle pulse.
  - Press latency from a clean input edge is 2 + (2^DEB_W-1) + 1 cycles.
- States: STOP, RUN, STEP, HALT.
  - STOP:
    - run press -> RUN, with the divider loaded with div_val.
    - step press -> STEP.
    - Otherwise stay in STOP.
  - RUN:
    - Divider decrements each cycle.
    - When the count is 0: clk_en=1 for that cycle and the divider reloads div_val.
    - div_val=0 gives clk_en on every cycle.
    - A div_val change mid-count takes effect at the next reload only.
    - run press -> STOP; a clk_en in the same cycle is still issued.
    - step press is ignored.
  - STEP: clk_en=1 for exactly one cycle, then -> STOP unconditionally.
  - HALT:
    - clk_en stays 0; all button presses are ignored.
    - Exit is by reset_n only.
- Halt entry:
  - halt_req=1 in any state -> HALT on the next edge.
  - halt_req has priority over a run or step press in the same cycle.
  - A clk_en already asserted in that cycle completes; no further clk_en is issued.
- Simultaneous run and step press in STOP: run wins.
- clk_en is registered, so the CPU samples it on the following edge.
- cpu_clk toggles on each cycle where clk_en=1.
- running=(state==RUN); halted=(state==HALT); both registered from next-state.
- Reset asserted mid-run: all outputs go to reset values immediately (asynchronous); no partial strobe.

Decomposition:
- Package clock_pkg holds:
  - ctrl_state_t enum {STOP, RUN, STEP, HALT}.
  - Default DIV_W and DEB_W localparams.
- Natural sub-module: btn_debounce, with synchroniser, saturating counter, hysteresis level and press-pulse output.
  - Instantiated twice, for run_btn and step_btn.
- The FSM and divider live in clock_ctrl.

Test Plan:
All scenarios use DEB_W=4 and DIV_W=8.
- Reset with RUN_AT_RESET=0: all outputs 0; no clk_en for 100 cycles.
- Run, div_val=3: run_btn held high 30 cycles -> running=1; clk_en once every 4 cycles; cpu_clk toggles each strobe.
  - Change div_val to 0 mid-count -> current period completes, then clk_en every cycle.
- Step: in STOP, step_btn held 30 cycles -> exactly one clk_en, state returns to STOP; holding the button longer produces no second strobe.
- Bounce rejection: run_btn toggled every 3 cycles for 40 cycles, then low -> no state change.
  - A single 10-cycle glitch -> no press.
- Halt: in RUN, pulse halt_req together with a run press -> halted=1, running=0, no clk_en afterwards; step/run presses are ignored; reset_n low -> STOP.
- Reset mid-run: assert reset_n between strobes -> clk_en, cpu_clk and running drop immediately; after release the divider restarts from 0.
